// File: rtl/wishbone_to_axi4lite.sv
// ============================================================================
// Module   : wishbone_to_axi4lite
// Purpose  : Wishbone classic slave to AXI4-Lite master bridge, one
//            transaction in flight. Optional macro WB2AXI_ERR_EN maps
//            SLVERR/DECERR responses onto wb_err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_to_axi4lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // Wishbone slave port
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    // AXI4-Lite master port
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_REQ  = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_REQ  = 3'd3;
    localparam logic [2:0] c_RD_RESP = 3'd4;
    localparam logic [2:0] c_TERM    = 3'd5;

    logic [2:0]              r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_arvalid;
    logic                    r_bready;
    logic                    r_rready;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_abort;
    logic                    r_ack;

    logic                    w_aw_fin;
    logic                    w_w_fin;
    logic                    w_cyc_ok;
    logic [1:0]              w_resp;

    // A handshake on this very edge counts as done for the WR_REQ exit test
    assign w_aw_fin = r_aw_done | (r_awvalid & AWREADY);
    assign w_w_fin  = r_w_done  | (r_wvalid  & WREADY);
    assign w_cyc_ok = wb_cyc_i & ~r_abort;
    assign w_resp   = (r_state == c_WR_RESP) ? BRESP : RRESP;

`ifdef WB2AXI_ERR_EN
    logic r_err;
    assign wb_err_o = r_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^w_resp;
    assign wb_err_o      = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= c_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_abort   <= 1'b0;
            r_ack     <= 1'b0;
`ifdef WB2AXI_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_ack   <= 1'b0;
                    r_abort <= 1'b0;
`ifdef WB2AXI_ERR_EN
                    r_err   <= 1'b0;
`endif
                    if (wb_cyc_i && wb_stb_i) begin
                        r_addr  <= wb_adr_i;
                        r_wdata <= wb_dat_i;
                        r_wstrb <= wb_sel_i;
                        if (wb_we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= c_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_RD_REQ;
                        end
                    end
                end
                c_WR_REQ: begin
                    if (r_awvalid && AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= c_WR_RESP;
                    end
                end
                c_WR_RESP, c_RD_RESP: begin
                    if ((r_state == c_WR_RESP) ? BVALID : RVALID) begin
                        r_bready <= 1'b0;
                        r_rready <= 1'b0;
                        if (r_state == c_RD_RESP) begin
                            r_rdata <= RDATA;
                        end
`ifdef WB2AXI_ERR_EN
                        r_ack <= w_cyc_ok & ~w_resp[1];
                        r_err <= w_cyc_ok &  w_resp[1];
`else
                        r_ack <= w_cyc_ok;
`endif
                        r_state <= c_TERM;
                    end
                end
                c_RD_REQ: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_RD_RESP;
                    end
                end
                c_TERM: begin
                    r_ack   <= 1'b0;
`ifdef WB2AXI_ERR_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
            // Once the master abandons the cycle, the termination stays suppressed
            if ((r_state != c_IDLE) && !wb_cyc_i) begin
                r_abort <= 1'b1;
            end
        end
    end

    assign wb_dat_o = r_rdata;
    assign wb_ack_o = r_ack;
    assign AWADDR   = r_addr;
    assign ARADDR   = r_addr;
    assign AWPROT   = 3'b000;
    assign ARPROT   = 3'b000;
    assign AWVALID  = r_awvalid;
    assign WDATA    = r_wdata;
    assign WSTRB    = r_wstrb;
    assign WVALID   = r_wvalid;
    assign BREADY   = r_bready;
    assign ARVALID  = r_arvalid;
    assign RREADY   = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_to_axi4lite.sv
// ============================================================================
// Module   : tb_wishbone_to_axi4lite
// Purpose  : Self-checking bench for wishbone_to_axi4lite with a delay-
//            programmable AXI4-Lite slave and latency/data reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_to_axi4lite;

`ifdef WB2AXI_ERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_w;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    always #5 clk = ~clk;

    wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          req_dly;   // AW (or AR) ready wait cycles
        int          w_dly;     // W ready wait cycles
        int          rsp_dly;   // B/R valid wait cycles
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    // Slave configuration and observation
    int          cfg_aw, cfg_w, cfg_ar, cfg_b, cfg_r;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int          bready_early, stab_err;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic        p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_araddr;
    logic [35:0] p_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            BRESP = 0; RRESP = 0; RDATA = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (AWVALID && p_awv && AWADDR != p_awaddr) stab_err++;
            if (WVALID && p_wv && {WDATA, WSTRB} != p_w) stab_err++;
            if (ARVALID && p_arv && ARADDR != p_araddr) stab_err++;
            p_awv = AWVALID; p_awaddr = AWADDR;
            p_wv  = WVALID;  p_w = {WDATA, WSTRB};
            p_arv = ARVALID; p_araddr = ARADDR;
            // Each ready set here pairs with a still-high VALID, so it handshakes next edge
            if (AWVALID) begin
                if (aw_cnt >= cfg_aw) begin AWREADY = 1; aw_hs++; cap_awaddr = AWADDR; end
                else begin AWREADY = 0; aw_cnt++; end
            end else begin AWREADY = 0; aw_cnt = 0; end
            if (WVALID) begin
                if (w_cnt >= cfg_w) begin WREADY = 1; w_hs++; cap_wdata = WDATA; cap_wstrb = WSTRB; end
                else begin WREADY = 0; w_cnt++; end
            end else begin WREADY = 0; w_cnt = 0; end
            if (ARVALID) begin
                if (ar_cnt >= cfg_ar) begin ARREADY = 1; ar_hs++; cap_araddr = ARADDR; end
                else begin ARREADY = 0; ar_cnt++; end
            end else begin ARREADY = 0; ar_cnt = 0; end
            if (BREADY) begin
                if (aw_hs == 0 || w_hs == 0) bready_early++;
                if (b_cnt >= cfg_b) begin BVALID = 1; BRESP = cfg_resp; b_hs++; end
                else begin BVALID = 0; b_cnt++; end
            end else begin BVALID = 0; BRESP = 0; b_cnt = 0; end
            if (RREADY) begin
                if (r_cnt >= cfg_r) begin RVALID = 1; RRESP = cfg_resp; RDATA = cfg_rdata; r_hs++; end
                else begin RVALID = 0; r_cnt++; end
            end else begin RVALID = 0; RRESP = 0; r_cnt = 0; end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input vec_t v, output int lat, output int first_v,
                        output logic got_ack, output logic got_err,
                        output logic [31:0] rd, output bit width_ok);
        cfg_aw = v.req_dly; cfg_ar = v.req_dly; cfg_w = v.w_dly;
        cfg_b = v.rsp_dly;  cfg_r = v.rsp_dly;
        cfg_resp = v.resp;  cfg_rdata = v.rdata;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = v.we;
        wb_adr = v.addr; wb_dat_w = v.data; wb_sel = v.sel;
        lat = 0; first_v = 0; got_ack = 0; got_err = 0; rd = 'x;
        while (lat < 200 && !(got_ack || got_err)) begin
            @(negedge clk);
            lat++;
            if (first_v == 0 && (AWVALID || ARVALID)) first_v = lat;
            if (wb_ack_o || wb_err_o) begin
                got_ack = wb_ack_o; got_err = wb_err_o; rd = wb_dat_o;
            end
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
        width_ok = !(wb_ack_o || wb_err_o);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, first_v, exp_lat;
        logic got_ack, got_err;
        logic [31:0] rd;
        bit width_ok, exp_err;
        exp_lat = 3 + v.rsp_dly +
                  (v.we ? ((v.req_dly > v.w_dly) ? v.req_dly : v.w_dly) : v.req_dly);
        exp_err = c_ERR_EN && v.resp[1];
        if (!v.we) model_rdata = v.rdata;
        xfer(v, lat, first_v, got_ack, got_err, rd, width_ok);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " valid_cycle"}, first_v, 1);
        check({tag, " ack"}, got_ack, !exp_err);
        check({tag, " err"}, got_err, exp_err);
        check({tag, " pulse_width"}, width_ok, 1);
        check({tag, " wb_dat_o"}, rd, model_rdata);
        if (v.we) begin
            check({tag, " hs_counts"}, {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0]}, 32'h01010100);
            check({tag, " aw_w_payload"}, {cap_awaddr, cap_wdata}, {v.addr, v.data});
            check({tag, " wstrb"}, cap_wstrb, v.sel);
        end else begin
            check({tag, " hs_counts"}, {ar_hs[7:0], r_hs[7:0], aw_hs[7:0], w_hs[7:0]}, 32'h01010000);
            check({tag, " araddr"}, cap_araddr, v.addr);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {wb_dat_o, wb_ack_o, wb_err_o, AWVALID, WVALID, BREADY, ARVALID, RREADY,
                AWPROT, ARPROT} | {AWADDR, WDATA} | {ARADDR, 28'd0, WSTRB};
    endfunction

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   k;
        bit   saw;

        vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_2004, 32'h0,         4'b0000, 0, 0, 5, 2'b00, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_3000, 32'h1111_2222, 4'b1111, 3, 0, 0, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_3004, 32'h3333_4444, 4'b0101, 0, 3, 0, 2'b00, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_3008, 32'h5555_6666, 4'b1010, 2, 2, 1, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_300C, 32'h7777_8888, 4'b1111, 0, 0, 0, 2'b10, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_4000, 32'h0,         4'b1111, 1, 0, 2, 2'b11, 32'hAAAA_5555};
        vecs[7] = '{1'b1, 32'h0000_5000, 32'h9999_0000, 4'b1000, 1, 2, 2, 2'b01, 32'h0};

        bready_early = 0; stab_err = 0; model_rdata = 0;
        cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_b = 0; cfg_r = 0; cfg_resp = 0; cfg_rdata = 0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_w = 0; wb_sel = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.data = $urandom; v.sel = 4'($urandom);
            v.req_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
            v.rsp_dly = $urandom_range(0, 3);
            v.resp = 2'($urandom); v.rdata = $urandom;
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Abort: master drops cyc while the read response is pending
        cfg_ar = 0; cfg_r = 4; cfg_resp = 0; cfg_rdata = 32'hCAFE_F00D;
        ar_hs = 0; r_hs = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0000_6000;
        k = 0;
        while (!RREADY && k < 20) begin @(negedge clk); k++; end
        check("abort_reach_rd_resp", RREADY, 1);
        wb_cyc = 0; wb_stb = 0;
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) saw = 1;
        end
        check("abort_no_ack", saw, 0);
        check("abort_r_handshake", r_hs, 1);
        v = '{1'b0, 32'h0000_6004, 32'h0, 4'b0000, 0, 0, 1, 2'b00, 32'h0BAD_F00D};
        run_vec(v, "after_abort");

        // Reset while AWVALID is pending
        cfg_aw = 5; cfg_w = 5; cfg_b = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h0000_7000; wb_dat_w = 32'h1234_ABCD; wb_sel = 4'hF;
        k = 0;
        while (!AWVALID && k < 20) begin @(negedge clk); k++; end
        check("pre_reset_awvalid", AWVALID, 1);
        #2 rst_n = 0;
        #1 check("async_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
        rst_n = 1;
        model_rdata = 0;
        @(negedge clk);
        v = '{1'b1, 32'h0000_7004, 32'h0F0F_F0F0, 4'b1100, 0, 0, 0, 2'b00, 32'h0};
        run_vec(v, "after_reset");

        check("valid_payload_stable", stab_err, 0);
        check("bready_after_both", bready_early, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
